// File: rtl/jtag_arb_pkg.sv
// Shared types for the JTAG target arbiter: the 1149.1 TAP state encoding,
// the arbiter FSM states and the TAP next-state function.
package jtag_arb_pkg;

    typedef enum logic [3:0] {
        TAP_EX2DR = 4'h0, TAP_EX1DR = 4'h1, TAP_SHDR  = 4'h2, TAP_PSDR  = 4'h3,
        TAP_SELIR = 4'h4, TAP_UPDR  = 4'h5, TAP_CAPDR = 4'h6, TAP_SELDR = 4'h7,
        TAP_EX2IR = 4'h8, TAP_EX1IR = 4'h9, TAP_SHIR  = 4'hA, TAP_PSIR  = 4'hB,
        TAP_RTI   = 4'hC, TAP_UPIR  = 4'hD, TAP_CAPIR = 4'hE, TAP_TLR   = 4'hF
    } tap_state_t;

    typedef enum logic [2:0] {
        ARB_CONNECTED,
        ARB_WAIT_SAFE,
        ARB_ISOLATE,
        ARB_RESET_SEQ,
        ARB_ALIGN,
        ARB_SETTLE
    } arb_state_t;

    function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
        tap_state_t n;
        n = TAP_TLR;
        case (s)
            TAP_TLR:   n = tms ? TAP_TLR   : TAP_RTI;
            TAP_RTI:   n = tms ? TAP_SELDR : TAP_RTI;
            TAP_SELDR: n = tms ? TAP_SELIR : TAP_CAPDR;
            TAP_CAPDR: n = tms ? TAP_EX1DR : TAP_SHDR;
            TAP_SHDR:  n = tms ? TAP_EX1DR : TAP_SHDR;
            TAP_EX1DR: n = tms ? TAP_UPDR  : TAP_PSDR;
            TAP_PSDR:  n = tms ? TAP_EX2DR : TAP_PSDR;
            TAP_EX2DR: n = tms ? TAP_UPDR  : TAP_SHDR;
            TAP_UPDR:  n = tms ? TAP_SELDR : TAP_RTI;
            TAP_SELIR: n = tms ? TAP_TLR   : TAP_CAPIR;
            TAP_CAPIR: n = tms ? TAP_EX1IR : TAP_SHIR;
            TAP_SHIR:  n = tms ? TAP_EX1IR : TAP_SHIR;
            TAP_EX1IR: n = tms ? TAP_UPIR  : TAP_PSIR;
            TAP_PSIR:  n = tms ? TAP_EX2IR : TAP_PSIR;
            TAP_EX2IR: n = tms ? TAP_UPIR  : TAP_SHIR;
            TAP_UPIR:  n = tms ? TAP_SELDR : TAP_RTI;
            default:   n = TAP_TLR;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/jtag_tap_tracker.sv
// Follows a TAP controller from synchronized tms plus a tck rising-edge strobe.
module jtag_tap_tracker
    import jtag_arb_pkg::*;
(
    input  logic       clk100,
    input  logic       cpu_reset,
    input  logic       tck_rise,
    input  logic       tms,
    output tap_state_t tap_state
);

    always_ff @(posedge clk100 or negedge cpu_reset) begin
        if (!cpu_reset) begin
            tap_state <= TAP_TLR;
        end else if (tck_rise) begin
            tap_state <= tap_next(tap_state, tms);
        end
    end

endmodule

// File: rtl/jtag_target_arbiter.sv
// Shares one host JTAG header between the SoC TAP and the test TAP, swapping
// only in TLR/RTI and replaying the host state into the new target first.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// CONNECTED | host wired straight through to active_sel target
// WAIT_SAFE | switch requested, waiting for host idle in TLR/RTI with tck low
// ISOLATE   | both targets parked, new target selected, host state latched
// RESET_SEQ | generated tck pulses with tms=1 force new target into TLR
// ALIGN     | one tms=0 pulse to move new target TLR -> RTI
// SETTLE    | generated tck held low, then reconnect
module jtag_target_arbiter
    import jtag_arb_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TCK_HALF    = 8,
    parameter int TLR_CLOCKS  = 5
) (
    input  logic       clk100,
    input  logic       cpu_reset,
    input  logic       tck,
    input  logic       tms,
    input  logic       tdi,
    output logic       tdo,
    input  logic       sel_req,
    output logic       soc_tck,
    output logic       soc_tms,
    output logic       soc_tdi,
    input  logic       soc_tdo,
    output logic       tesic_tck,
    output logic       tesic_tms,
    output logic       tesic_tdi,
    input  logic       tesic_tdo,
    output logic       active_sel,
    output logic       busy,
    output logic       sync_err,
    output logic [3:0] tap_state
);

    localparam int DIV_W   = $clog2(TCK_HALF + 1);
    localparam int PULSE_W = $clog2(TLR_CLOCKS + 1);
    localparam logic [DIV_W-1:0]   HALF_LOAD  = DIV_W'(TCK_HALF - 1);
    localparam logic [PULSE_W-1:0] PULSE_LOAD = PULSE_W'(TLR_CLOCKS - 1);

    logic [SYNC_STAGES-1:0] tck_sync;
    logic [SYNC_STAGES-1:0] tms_sync;
    logic                   tck_s_d;
    logic                   tck_s;
    logic                   tck_rise;
    logic                   host_safe;
    tap_state_t             host_state;
    tap_state_t             target_state;
    arb_state_t             state;
    logic                   iso;
    logic                   gen_tck;
    logic                   gen_tms;
    logic [DIV_W-1:0]       div_cnt;
    logic [PULSE_W-1:0]     pulse_cnt;

    // tdi is only ever passed through raw, so only tck/tms are synchronized
    always_ff @(posedge clk100 or negedge cpu_reset) begin
        if (!cpu_reset) begin
            tck_sync <= '0;
            tms_sync <= '1;
            tck_s_d  <= 1'b0;
        end else begin
            tck_sync <= {tck_sync[SYNC_STAGES-2:0], tck};
            tms_sync <= {tms_sync[SYNC_STAGES-2:0], tms};
            tck_s_d  <= tck_sync[SYNC_STAGES-1];
        end
    end

    assign tck_s     = tck_sync[SYNC_STAGES-1];
    assign tck_rise  = tck_s & ~tck_s_d;
    assign host_safe = ((host_state == TAP_TLR) || (host_state == TAP_RTI)) && !tck_s && !tck_s_d;
    assign tap_state = host_state;

    jtag_tap_tracker u_host_tracker (
        .clk100    (clk100),
        .cpu_reset (cpu_reset),
        .tck_rise  (tck_rise),
        .tms       (tms_sync[SYNC_STAGES-1]),
        .tap_state (host_state)
    );

    always_ff @(posedge clk100 or negedge cpu_reset) begin
        if (!cpu_reset) begin
            state        <= ARB_CONNECTED;
            active_sel   <= 1'b0;
            busy         <= 1'b0;
            iso          <= 1'b0;
            sync_err     <= 1'b0;
            gen_tck      <= 1'b0;
            gen_tms      <= 1'b1;
            div_cnt      <= '0;
            pulse_cnt    <= '0;
            target_state <= TAP_TLR;
        end else begin
            if (iso && tck_rise) begin
                sync_err <= 1'b1;
            end
            case (state)
                ARB_CONNECTED: begin
                    if (sel_req != active_sel) begin
                        state    <= ARB_WAIT_SAFE;
                        busy     <= 1'b1;
                        sync_err <= 1'b0;
                    end
                end
                ARB_WAIT_SAFE: begin
                    if (sel_req == active_sel) begin
                        state <= ARB_CONNECTED;
                        busy  <= 1'b0;
                    end else if (host_safe) begin
                        state        <= ARB_ISOLATE;
                        iso          <= 1'b1;
                        active_sel   <= sel_req;
                        target_state <= host_state;
                        gen_tck      <= 1'b0;
                        gen_tms      <= 1'b1;
                    end
                end
                ARB_ISOLATE: begin
                    state     <= ARB_RESET_SEQ;
                    div_cnt   <= HALF_LOAD;
                    pulse_cnt <= PULSE_LOAD;
                end
                ARB_RESET_SEQ: begin
                    if (div_cnt != '0) begin
                        div_cnt <= div_cnt - 1'b1;
                    end else begin
                        div_cnt <= HALF_LOAD;
                        gen_tck <= ~gen_tck;
                        if (gen_tck) begin
                            if (pulse_cnt != '0) begin
                                pulse_cnt <= pulse_cnt - 1'b1;
                            end else if (target_state == TAP_RTI) begin
                                state   <= ARB_ALIGN;
                                gen_tms <= 1'b0;
                            end else begin
                                state <= ARB_SETTLE;
                            end
                        end
                    end
                end
                ARB_ALIGN: begin
                    if (div_cnt != '0) begin
                        div_cnt <= div_cnt - 1'b1;
                    end else begin
                        div_cnt <= HALF_LOAD;
                        gen_tck <= ~gen_tck;
                        if (gen_tck) begin
                            state <= ARB_SETTLE;
                        end
                    end
                end
                ARB_SETTLE: begin
                    if (div_cnt != '0) begin
                        div_cnt <= div_cnt - 1'b1;
                    end else begin
                        state   <= ARB_CONNECTED;
                        iso     <= 1'b0;
                        busy    <= 1'b0;
                        gen_tms <= 1'b1;
                    end
                end
                default: state <= ARB_CONNECTED;
            endcase
        end
    end

    // gen_tck/gen_tms sit at their parked values during ISOLATE
    always_comb begin
        soc_tck   = 1'b0;
        soc_tms   = 1'b1;
        soc_tdi   = 1'b0;
        tesic_tck = 1'b0;
        tesic_tms = 1'b1;
        tesic_tdi = 1'b0;
        tdo       = 1'b0;
        if (iso) begin
            if (active_sel) begin
                tesic_tck = gen_tck;
                tesic_tms = gen_tms;
            end else begin
                soc_tck = gen_tck;
                soc_tms = gen_tms;
            end
        end else if (active_sel) begin
            tesic_tck = tck;
            tesic_tms = tms;
            tesic_tdi = tdi;
            tdo       = tesic_tdo;
        end else begin
            soc_tck = tck;
            soc_tms = tms;
            soc_tdi = tdi;
            tdo     = soc_tdo;
        end
    end

endmodule

// File: tb/tb_jtag_target_arbiter.sv
// Directed bench for jtag_target_arbiter: pass-through, switching from RTI,
// SHDR and TLR, aborted request, sync_err and reset mid-switch.
module tb_jtag_target_arbiter;

    logic       clk100 = 1'b0;
    logic       cpu_reset = 1'b0;
    logic       tck = 1'b0;
    logic       tms = 1'b1;
    logic       tdi = 1'b0;
    logic       sel_req = 1'b0;
    logic       soc_tdo = 1'b0;
    logic       tesic_tdo = 1'b0;
    logic       tdo;
    logic       soc_tck, soc_tms, soc_tdi;
    logic       tesic_tck, tesic_tms, tesic_tdi;
    logic       active_sel, busy, sync_err;
    logic [3:0] tap_state;

    int n_cmp = 0;
    int n_err = 0;
    int soc_p1 = 0, soc_p0 = 0, tes_p1 = 0, tes_p0 = 0;
    int snap1, snap0;

    jtag_target_arbiter dut (
        .clk100     (clk100),
        .cpu_reset  (cpu_reset),
        .tck        (tck),
        .tms        (tms),
        .tdi        (tdi),
        .tdo        (tdo),
        .sel_req    (sel_req),
        .soc_tck    (soc_tck),
        .soc_tms    (soc_tms),
        .soc_tdi    (soc_tdi),
        .soc_tdo    (soc_tdo),
        .tesic_tck  (tesic_tck),
        .tesic_tms  (tesic_tms),
        .tesic_tdi  (tesic_tdi),
        .tesic_tdo  (tesic_tdo),
        .active_sel (active_sel),
        .busy       (busy),
        .sync_err   (sync_err),
        .tap_state  (tap_state)
    );

    always #5 clk100 = ~clk100;

    always @(posedge soc_tck) begin
        if (soc_tms) soc_p1++; else soc_p0++;
    end

    always @(posedge tesic_tck) begin
        if (tesic_tms) tes_p1++; else tes_p0++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one host tck period of 100 ns, well under the synchronizer limit
    task automatic host_clk(input logic tms_v);
        tms = tms_v;
        #50 tck = 1'b1;
        #50 tck = 1'b0;
    endtask

    task automatic wait_busy_rise(input string tag);
        for (int i = 0; i < 5 && !busy; i++) @(negedge clk100);
        chk(tag, busy, 1);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 1000 && busy; i++) @(negedge clk100);
        chk(tag, busy, 0);
    endtask

    logic       walk_tms [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0] walk_exp [4] = '{4'hC, 4'h7, 4'h6, 4'h2};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset values while cpu_reset is held low
        #23;
        chk("rst_active_sel", active_sel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sync_err", sync_err, 0);
        chk("rst_tap_state", tap_state, 4'hF);
        chk("rst_tesic_tck", tesic_tck, 0);
        chk("rst_tesic_tms", tesic_tms, 1);
        chk("rst_soc_tms", soc_tms, 1);
        cpu_reset = 1'b1;
        repeat (3) @(negedge clk100);

        // TLR -> RTI -> SELDR -> CAPDR -> SHDR, then 32 shift clocks
        for (int i = 0; i < 4; i++) begin
            host_clk(walk_tms[i]);
            chk("tap_walk", tap_state, walk_exp[i]);
        end
        for (int i = 0; i < 32; i++) begin
            tms = (i == 31);
            tdi = i[0];
            soc_tdo = i[1];
            tesic_tdo = ~i[1];
            #50 tck = 1'b1;
            #1;
            if (i == 0 || i == 5) begin
                chk("soc_tck_mirror", soc_tck, 1);
                chk("soc_tdi_mirror", soc_tdi, tdi);
                chk("tdo_from_soc", tdo, soc_tdo);
            end
            #49 tck = 1'b0;
        end
        chk("tap_ex1dr", tap_state, 4'h1);
        host_clk(1'b1);
        chk("tap_updr", tap_state, 4'h5);
        host_clk(1'b0);
        chk("tap_rti", tap_state, 4'hC);
        chk("tesic_idle_pulses", tes_p1 + tes_p0, 0);

        // switch to tesic from RTI: 5 tms=1 pulses then 1 tms=0 pulse
        snap1 = tes_p1;
        snap0 = tes_p0;
        @(negedge clk100);
        sel_req = 1'b1;
        wait_busy_rise("rti_busy_rise");
        wait_idle("rti_busy_fall");
        chk("rti_tms1_pulses", tes_p1 - snap1, 5);
        chk("rti_tms0_pulses", tes_p0 - snap0, 1);
        chk("rti_active_sel", active_sel, 1);
        chk("rti_soc_parked", {soc_tck, soc_tms, soc_tdi}, 3'b010);
        tesic_tdo = 1'b1;
        soc_tdo = 1'b0;
        #1 chk("tdo_from_tesic", tdo, 1);
        tesic_tdo = 1'b0;
        #1 chk("tdo_from_tesic0", tdo, 0);

        // switch back to soc requested while host shifts DR
        host_clk(1'b1);
        host_clk(1'b0);
        host_clk(1'b0);
        chk("shdr_reached", tap_state, 4'h2);
        snap1 = soc_p1;
        snap0 = soc_p0;
        sel_req = 1'b0;
        repeat (10) @(negedge clk100);
        chk("shdr_busy_wait", busy, 1);
        chk("shdr_active_hold", active_sel, 1);
        tms = 1'b0;
        #50 tck = 1'b1;
        #1 chk("shdr_tesic_follows", tesic_tck, 1);
        #49 tck = 1'b0;
        repeat (10) @(negedge clk100);
        chk("shdr_still_waiting", busy, 1);
        chk("shdr_no_gen_pulses", soc_p1 + soc_p0 - snap1 - snap0, 0);
        host_clk(1'b1);
        host_clk(1'b1);
        host_clk(1'b0);
        wait_idle("shdr_busy_fall");
        chk("shdr_tms1_pulses", soc_p1 - snap1, 5);
        chk("shdr_tms0_pulses", soc_p0 - snap0, 1);
        chk("shdr_active_sel", active_sel, 0);
        chk("shdr_tesic_parked", tesic_tms, 1);

        // short request pulse while in SHDR is abandoned
        host_clk(1'b1);
        host_clk(1'b0);
        host_clk(1'b0);
        snap1 = tes_p1;
        snap0 = tes_p0;
        @(negedge clk100);
        sel_req = 1'b1;
        repeat (3) @(negedge clk100);
        chk("abort_busy", busy, 1);
        sel_req = 1'b0;
        repeat (3) @(negedge clk100);
        chk("abort_busy_clear", busy, 0);
        chk("abort_active_sel", active_sel, 0);
        chk("abort_no_pulses", tes_p1 + tes_p0 - snap1 - snap0, 0);
        host_clk(1'b1);
        host_clk(1'b1);
        host_clk(1'b0);
        chk("abort_back_rti", tap_state, 4'hC);

        // host edge during RESET_SEQ sets sticky sync_err
        @(negedge clk100);
        sel_req = 1'b1;
        wait_busy_rise("err_busy_rise");
        repeat (20) @(negedge clk100);
        chk("err_clear_before", sync_err, 0);
        host_clk(1'b0);
        repeat (2) @(negedge clk100);
        chk("err_set", sync_err, 1);
        wait_idle("err_busy_fall");
        chk("err_sticky", sync_err, 1);
        chk("err_active_sel", active_sel, 1);
        sel_req = 1'b0;
        repeat (3) @(negedge clk100);
        chk("err_cleared", sync_err, 0);
        wait_idle("err_back_idle");
        chk("err_back_soc", active_sel, 0);

        // switch from TLR skips the alignment pulse
        host_clk(1'b1);
        host_clk(1'b1);
        host_clk(1'b1);
        chk("tlr_reached", tap_state, 4'hF);
        snap1 = tes_p1;
        snap0 = tes_p0;
        @(negedge clk100);
        sel_req = 1'b1;
        wait_busy_rise("tlr_busy_rise");
        wait_idle("tlr_busy_fall");
        chk("tlr_tms1_pulses", tes_p1 - snap1, 5);
        chk("tlr_tms0_pulses", tes_p0 - snap0, 0);
        chk("tlr_active_sel", active_sel, 1);

        // reset in the middle of RESET_SEQ
        tms = 1'b0;
        @(negedge clk100);
        sel_req = 1'b0;
        repeat (30) @(negedge clk100);
        chk("mid_busy", busy, 1);
        chk("mid_soc_gen_tms", soc_tms, 1);
        #2 cpu_reset = 1'b0;
        #1;
        chk("mid_rst_active_sel", active_sel, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_tap", tap_state, 4'hF);
        chk("mid_rst_soc_raw_tms", soc_tms, 0);
        chk("mid_rst_tesic_parked", {tesic_tck, tesic_tms, tesic_tdi}, 3'b010);
        @(negedge clk100);
        cpu_reset = 1'b1;
        repeat (5) @(negedge clk100);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_active_sel", active_sel, 0);
        chk("post_rst_tap", tap_state, 4'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
